// File: rtl/switch_commit_controller.sv
// switch_commit_controller
// Debounces the COMMIT button, snapshots the switch bus on one clean press,
// offers the word over valid/ready, and enforces one commit per press.
module switch_commit_controller #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] sw_sync,
    input  logic             btn_sync,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic             busy,
    output logic [7:0]       commit_count
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] ST_IDLE         = 2'd0;
    localparam logic [1:0] ST_DEBOUNCE     = 2'd1;
    localparam logic [1:0] ST_OFFER        = 2'd2;
    localparam logic [1:0] ST_WAIT_RELEASE = 2'd3;

    logic [1:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_data_out;
    logic             r_data_valid;
    logic             r_busy;
    logic [7:0]       r_commit_count;

    logic [1:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             w_capture;
    logic             w_accept;

    // Next-state and counter logic for the press/offer/release sequence
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_accept    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (btn_sync) begin
                    w_state_nxt = ST_DEBOUNCE;
                    w_cnt_nxt   = '0;
                end
            end
            ST_DEBOUNCE: begin
                if (!btn_sync) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_capture   = 1'b1;
                    w_state_nxt = ST_OFFER;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            ST_OFFER: begin
                if (data_ready) begin
                    w_accept    = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_WAIT_RELEASE;
                end
            end
            ST_WAIT_RELEASE: begin
                if (btn_sync) begin
                    w_cnt_nxt = '0;
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Registered state, counter and all outputs; busy is registered from the next state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= ST_IDLE;
            r_cnt          <= '0;
            r_data_out     <= '0;
            r_data_valid   <= 1'b0;
            r_busy         <= 1'b0;
            r_commit_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            if (w_capture) begin
                r_data_out   <= sw_sync;
                r_data_valid <= 1'b1;
            end else if (w_accept) begin
                r_data_valid <= 1'b0;
            end
            if (w_accept) begin
                r_commit_count <= r_commit_count + 8'd1;
            end
        end
    end

    assign data_out     = r_data_out;
    assign data_valid   = r_data_valid;
    assign busy         = r_busy;
    assign commit_count = r_commit_count;

endmodule
